// File: rtl/prog_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : prog_fetch_unit
// Description : Program counter and instruction-fetch stage. Addresses a
//               synchronous instruction ROM, splits each returned word into
//               opcode/operand for the decoder and resolves JMP, JZ, CALL and
//               RETURN locally with a return-address stack. Every taken
//               redirect is followed by exactly one squashed bubble cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_fetch_unit #(
    parameter int NBDATA = 32,
    parameter int NBOPCO = 6,
    parameter int NBOPER = 9,
    parameter int MINSTW = 9,
    parameter int SDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [MINSTW-1:0]         instr_addr,
    input  logic [NBOPCO+NBOPER-1:0]  instr_in,
    input  logic [NBDATA-1:0]         acc_in,
    output logic [NBOPCO-1:0]         opcode,
    output logic [NBOPER-1:0]         operand,
    output logic                      valid,
    output logic [$clog2(SDEPTH):0]   rs_depth,
    output logic                      rs_ovf,
    output logic                      rs_unf
);

    localparam int c_SPW  = $clog2(SDEPTH) + 1;
    localparam int c_SPAW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    localparam logic [NBOPCO-1:0] c_OP_JZ     = NBOPCO'(5);
    localparam logic [NBOPCO-1:0] c_OP_JMP    = NBOPCO'(6);
    localparam logic [NBOPCO-1:0] c_OP_CALL   = NBOPCO'(7);
    localparam logic [NBOPCO-1:0] c_OP_RETURN = NBOPCO'(8);

    // BOOT: ROM output not yet meaningful; RUN: instr_in valid;
    // FLUSH: instr_in is the wrong-path word behind a redirect.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MINSTW-1:0]   r_pc;
    logic [MINSTW-1:0]   r_ex_pc;
    logic [MINSTW-1:0]   w_pc_nxt;
    logic [MINSTW-1:0]   w_ret_addr;
    logic [MINSTW-1:0]   r_rs [SDEPTH];
    logic [c_SPW-1:0]    r_sp;
    logic [c_SPW-1:0]    w_sp_nxt;
    logic [c_SPAW-1:0]   w_wr_idx;
    logic [c_SPAW-1:0]   w_rd_idx;
    logic                r_ovf;
    logic                r_unf;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic                w_push;
    logic                w_redirect;
    logic                w_stack_full;
    logic                w_stack_empty;
    logic                w_valid;
    logic [NBOPCO-1:0]   w_op;

    assign w_op          = instr_in[NBOPCO+NBOPER-1:NBOPER];
    assign w_valid       = (r_state == S_RUN);
    assign w_ret_addr    = r_ex_pc + MINSTW'(1);
    assign w_wr_idx      = c_SPAW'(r_sp);
    assign w_rd_idx      = c_SPAW'(r_sp - c_SPW'(1));
    assign w_stack_full  = (r_sp == c_SPW'(SDEPTH));
    assign w_stack_empty = (r_sp == '0);

    // Next-state, next-pc and stack control; redirects only act on a valid word.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc + MINSTW'(1);
        w_sp_nxt    = r_sp;
        w_redirect  = 1'b0;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_FLUSH: w_state_nxt = S_RUN;
            S_RUN: begin
                case (w_op)
                    c_OP_JMP: begin
                        w_redirect = 1'b1;
                        w_pc_nxt   = instr_in[MINSTW-1:0];
                    end
                    c_OP_JZ: begin
                        if (acc_in == '0) begin
                            w_redirect = 1'b1;
                            w_pc_nxt   = instr_in[MINSTW-1:0];
                        end
                    end
                    c_OP_CALL: begin
                        // The jump is taken even when the push has to be dropped.
                        w_redirect = 1'b1;
                        w_pc_nxt   = instr_in[MINSTW-1:0];
                        if (w_stack_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_push   = 1'b1;
                            w_sp_nxt = r_sp + c_SPW'(1);
                        end
                    end
                    c_OP_RETURN: begin
                        // Underflow degrades to a fall-through no-op.
                        if (w_stack_empty) begin
                            w_unf_set = 1'b1;
                        end else begin
                            w_redirect = 1'b1;
                            w_pc_nxt   = r_rs[w_rd_idx];
                            w_sp_nxt   = r_sp - c_SPW'(1);
                        end
                    end
                    default: ;
                endcase
                w_state_nxt = w_redirect ? S_FLUSH : S_RUN;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Control registers: pc, fetch-address tracker, state, stack pointer, sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= '0;
            r_ex_pc <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ex_pc <= r_pc;
            r_sp    <= w_sp_nxt;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) r_rs[w_wr_idx] <= w_ret_addr;
    end

    assign instr_addr = r_pc;
    assign valid      = w_valid;
    assign opcode     = w_valid ? w_op : c_OP_JMP;
    assign operand    = w_valid ? instr_in[NBOPER-1:0] : '0;
    assign rs_depth   = r_sp;
    assign rs_ovf     = r_ovf;
    assign rs_unf     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_prog_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_fetch_unit
// Description : Self-checking bench for prog_fetch_unit. An instruction-level
//               interpreter predicts the per-cycle decoder stream into a
//               scoreboard queue; a monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  instr_addr;
    logic [14:0] instr_in = '0;
    logic [31:0] acc_in = '0;
    logic [5:0]  opcode;
    logic [8:0]  operand;
    logic        valid;
    logic [3:0]  rs_depth;
    logic        rs_ovf;
    logic        rs_unf;

    always #5 clk = ~clk;

    prog_fetch_unit #(
        .NBDATA(32), .NBOPCO(6), .NBOPER(9), .MINSTW(9), .SDEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_in(instr_in),
        .acc_in(acc_in), .opcode(opcode), .operand(operand), .valid(valid),
        .rs_depth(rs_depth), .rs_ovf(rs_ovf), .rs_unf(rs_unf)
    );

    // Synchronous ROM: word appears one cycle after its address.
    logic [14:0] rom [512];
    always @(posedge clk) instr_in <= rom[instr_addr];

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [8:0] opr;
        logic [8:0] ia;
        logic [3:0] dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference machine state (instruction-level view).
    int   m_pc;
    bit   m_bub;
    bit   m_last_call;
    int   m_stk[$];
    bit   m_ovf;
    bit   m_unf;

    function automatic logic [14:0] mk(input int op, input int opr);
        logic [5:0] o;
        logic [8:0] d;
        o = 6'(op);
        d = 9'(opr);
        return {o, d};
    endfunction

    function automatic void m_reset();
        m_pc = 0; m_bub = 0; m_last_call = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    endfunction

    // Predict what the decoder sees this cycle, then execute the instruction.
    function automatic void m_step(input logic [31:0] acc);
        exp_t       e;
        logic [14:0] w;
        int         op;
        int         opr;
        int         nxt;
        bit         red;
        if (m_bub) begin
            e.v = 1'b0; e.op = 6'd6; e.opr = '0; e.ia = 9'(m_pc);
            e.dep = 4'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
            exp_q.push_back(e);
            m_bub = 0; m_last_call = 0;
            return;
        end
        w   = rom[m_pc];
        op  = int'(w[14:9]);
        opr = int'(w[8:0]);
        e.v = 1'b1; e.op = 6'(op); e.opr = 9'(opr); e.ia = 9'((m_pc + 1) % 512);
        e.dep = 4'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
        nxt = (m_pc + 1) % 512;
        red = 0;
        m_last_call = 0;
        if (op == 6) begin
            nxt = opr; red = 1;
        end else if (op == 5) begin
            if (acc == 0) begin nxt = opr; red = 1; end
        end else if (op == 7) begin
            if (m_stk.size() < 8) m_stk.push_back((m_pc + 1) % 512);
            else m_ovf = 1;
            nxt = opr; red = 1; m_last_call = 1;
        end else if (op == 8) begin
            if (m_stk.size() > 0) begin nxt = m_stk.pop_back(); red = 1; end
            else m_unf = 1;
        end
        m_pc  = nxt;
        m_bub = red;
    endfunction

    // Monitor: the DUT presents a decoder word every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {valid, opcode, operand, instr_addr, rs_depth, rs_ovf, rs_unf};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out @%0t: got v=%0b op=%0d opr=%h ia=%h dep=%0d ovf=%0b unf=%0b, expected v=%0b op=%0d opr=%h ia=%h dep=%0d ovf=%0b unf=%0b",
                         $time, a.v, a.op, a.opr, a.ia, a.dep, a.ovf, a.unf,
                         e.v, e.op, e.opr, e.ia, e.dep, e.ovf, e.unf);
            end
        end
    end

    task automatic chk_reset(input string name);
        logic [30:0] got;
        logic [30:0] want;
        got  = {valid, opcode, operand, instr_addr, rs_depth, rs_ovf, rs_unf};
        want = {1'b0, 6'd6, 9'd0, 9'd0, 4'd0, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] pick_acc(input int mode);
        if (mode == 0) return 32'd0;
        if (mode == 1) return 32'd7;
        return ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
    endfunction

    task automatic load_dir();
        for (int i = 0; i < 512; i++) rom[i] = mk(1, i);
        rom[9'h000] = mk(0, 1);      rom[9'h001] = mk(14, 2);
        rom[9'h002] = mk(2, 3);      rom[9'h003] = mk(5, 'h10);
        rom[9'h004] = mk(11, 0);     rom[9'h005] = mk(6, 'h40);
        rom[9'h010] = mk(1, 5);      rom[9'h011] = mk(6, 'h20);
        rom[9'h020] = mk(7, 'h80);   rom[9'h021] = mk(11, 1);
        rom[9'h022] = mk(6, 'h1FD);
        rom[9'h1FD] = mk(2, 0);      rom[9'h1FE] = mk(0, 0);
        rom[9'h1FF] = mk(7, 'h30);   rom[9'h030] = mk(8, 0);
        rom[9'h040] = mk(7, 'h80);   rom[9'h041] = mk(6, 'h50);
        rom[9'h080] = mk(3, 0);      rom[9'h081] = mk(8, 0);
        // Nine nested calls (ninth overflows), each return site holds RETURN.
        for (int i = 0; i < 9; i++) begin
            rom['h50 + 2*i] = mk(7, 'h52 + 2*i);
            rom['h51 + 2*i] = mk(8, 0);
        end
        rom[9'h062] = mk(8, 0);
    endtask

    task automatic load_rand();
        for (int i = 0; i < 512; i++) begin
            case ($urandom_range(0, 9))
                0:       rom[i] = mk(6, $urandom_range(0, 511));
                1:       rom[i] = mk(5, $urandom_range(0, 511));
                2:       rom[i] = mk(7, $urandom_range(0, 511));
                3:       rom[i] = mk(8, $urandom_range(0, 511));
                default: rom[i] = mk($urandom_range(9, 63), $urandom_range(0, 511));
            endcase
        end
    endtask

    // One program run from reset; optionally aborts once in the bubble after a CALL.
    task automatic run(input int n, input int amode, input bit abort_en);
        bit ab;
        ab     = abort_en;
        rst    = 1'b1;
        acc_in = '0;
        @(posedge clk); #1;
        chk_reset("reset_hold");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (ab && m_bub && m_last_call) begin
                ab  = 0;
                rst = 1'b1;
                #1;
                chk_reset("reset_in_flush");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                m_reset();
                @(posedge clk); #1;
            end
            acc_in = pick_acc(amode);
            m_step(acc_in);
        end
        @(negedge clk); #2;
    endtask

    initial begin
        load_dir();
        run(300, 0, 1'b0);
        run(300, 1, 1'b0);
        run(600, 2, 1'b1);
        load_rand();
        run(2000, 2, 1'b0);
        load_rand();
        run(2000, 2, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
